// File: rtl/conv_window_fetcher.sv
// conv_window_fetcher: fetches every K x K stride-1 window of a stored map; define COLUMN_REUSE_EN to reuse columns on horizontal steps
module conv_window_fetcher #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 5,
    localparam int ADDR_W    = $clog2(IMG_W * IMG_H),
    localparam int RW        = $clog2(IMG_H),
    localparam int CW        = $clog2(IMG_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Start,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Mem_Enable_Read,
    output logic [ADDR_W-1:0]          Mem_Address,
    input  logic [DATA_WIDTH-1:0]      Mem_Data,
    output logic                       Window_Valid,
    input  logic                       Window_Ready,
    output logic [K*K*DATA_WIDTH-1:0]  Window,
    output logic [RW-1:0]              Win_Row,
    output logic [CW-1:0]              Win_Col
);
    localparam int KW = $clog2(K + 1);
    localparam int SW = $clog2(K * K);
    localparam logic [KW-1:0] KL = KW'(K - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

    state_t            state;
    logic [KW-1:0]     fkr, fkc, nkr, nkc, fkc0, kc0;
    logic              rd_vld, last_col, last_win;
    logic [SW-1:0]     rd_slot;
    logic [RW-1:0]     nrow;
    logic [CW-1:0]     ncol;

    function automatic logic [ADDR_W-1:0] addr_of(input int r, input int c);
        return ADDR_W'(r * IMG_W + c);
    endfunction

    // next read index within the window and next window coordinate after a handshake
    always_comb begin
        last_col = Win_Col == CW'(IMG_W - K);
        last_win = last_col && Win_Row == RW'(IMG_H - K);
        nrow     = last_col ? Win_Row + RW'(1) : Win_Row;
        ncol     = last_col ? '0 : Win_Col + CW'(1);
`ifdef COLUMN_REUSE_EN
        kc0      = last_col ? '0 : KL;
        fkc0     = (Win_Col != '0) ? KL : '0;
`else
        kc0      = '0;
        fkc0     = '0;
`endif
        nkc      = (fkc == KL) ? fkc0 : fkc + KW'(1);
        nkr      = (fkc == KL) ? fkr + KW'(1) : fkr;
    end

    // window walk FSM: issue reads, capture returned pixels into their slots, hold window until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Mem_Enable_Read <= 1'b0;
            Mem_Address     <= '0;
            Window_Valid    <= 1'b0;
            Window          <= '0;
            Win_Row         <= '0;
            Win_Col         <= '0;
            fkr             <= '0;
            fkc             <= '0;
            rd_vld          <= 1'b0;
            rd_slot         <= '0;
        end else begin
            rd_vld  <= Mem_Enable_Read;
            rd_slot <= SW'(int'(fkr) * K + int'(fkc));
            if (rd_vld)
                Window[rd_slot*DATA_WIDTH +: DATA_WIDTH] <= Mem_Data;
            Done <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    state           <= FETCH;
                    Busy            <= 1'b1;
                    Win_Row         <= '0;
                    Win_Col         <= '0;
                    fkr             <= '0;
                    fkc             <= '0;
                    Mem_Enable_Read <= 1'b1;
                    Mem_Address     <= '0;
                end
                FETCH: if (fkr == KL && fkc == KL) begin
                    Mem_Enable_Read <= 1'b0;
                    state           <= DRAIN;
                end else begin
                    fkr         <= nkr;
                    fkc         <= nkc;
                    Mem_Address <= addr_of(int'(Win_Row) + int'(nkr), int'(Win_Col) + int'(nkc));
                end
                DRAIN: begin
                    state        <= PRESENT;
                    Window_Valid <= 1'b1;
                end
                PRESENT: if (Window_Ready) begin
                    Window_Valid <= 1'b0;
                    if (last_win) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        state           <= FETCH;
                        Mem_Enable_Read <= 1'b1;
                        Win_Row         <= nrow;
                        Win_Col         <= ncol;
                        fkr             <= '0;
                        fkc             <= kc0;
                        Mem_Address     <= addr_of(int'(nrow), int'(ncol) + int'(kc0));
`ifdef COLUMN_REUSE_EN
                        if (!last_col)
                            for (int i = 0; i < K * K; i++)
                                if (i % K != K - 1)
                                    Window[i*DATA_WIDTH +: DATA_WIDTH] <= Window[(i+1)*DATA_WIDTH +: DATA_WIDTH];
`endif
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_fetcher.sv
// tb_conv_window_fetcher: directed bench with value==address memory and hand-computed windows
module tb_conv_window_fetcher;
    localparam int DW = 32;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K = 5;
    localparam int AW = $clog2(IMG_W * IMG_H);
    localparam int NC = IMG_W - K + 1;
    localparam int NW = NC * (IMG_H - K + 1);
`ifdef COLUMN_REUSE_EN
    localparam int EXP_READS = 3360;
`else
    localparam int EXP_READS = 14400;
`endif

    logic              clk = 0;
    logic              rst = 1;
    logic              Start = 0;
    logic              Busy, Done, Mem_Enable_Read, Window_Valid;
    logic              Window_Ready = 0;
    logic [AW-1:0]     Mem_Address;
    logic [DW-1:0]     Mem_Data = '0;
    logic [K*K*DW-1:0] Window;
    logic [4:0]        Win_Row, Win_Col;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int max_addr = 0;

    conv_window_fetcher dut (
        .clk(clk), .rst(rst), .Start(Start), .Busy(Busy), .Done(Done),
        .Mem_Enable_Read(Mem_Enable_Read), .Mem_Address(Mem_Address), .Mem_Data(Mem_Data),
        .Window_Valid(Window_Valid), .Window_Ready(Window_Ready), .Window(Window),
        .Win_Row(Win_Row), .Win_Col(Win_Col)
    );

    always #5 clk = ~clk;

    // memory with 1-cycle read latency holding value == address, plus read/done bookkeeping
    always @(posedge clk) begin
        if (Mem_Enable_Read) begin
            Mem_Data <= DW'(Mem_Address);
            rd_cnt   <= rd_cnt + 1;
            if (int'(Mem_Address) > max_addr) max_addr <= int'(Mem_Address);
        end
        if (Done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [K*K*DW-1:0] exp_win(input int r, input int c);
        logic [K*K*DW-1:0] w;
        for (int i = 0; i < K * K; i++) w[i*DW +: DW] = DW'((r + i / K) * IMG_W + c + i % K);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input int idx);
        int r, c;
        r = idx / NC;
        c = idx % NC;
        n_cmp++;
        assert (Window === exp_win(r, c) && Win_Row === 5'(r) && Win_Col === 5'(c)) else begin
            n_err++;
            $error("FAIL win[%0d]: observed (%0d,%0d) elem0=%0d elem24=%0d expected (%0d,%0d) elem0=%0d elem24=%0d",
                   idx, Win_Row, Win_Col, Window[0 +: DW], Window[24*DW +: DW], r, c,
                   r * IMG_W + c, (r + 4) * IMG_W + c + 4);
        end
        if (idx == 0) begin
            chk("w00_e0", 64'(Window[0 +: DW]), 0);
            chk("w00_e4", 64'(Window[4*DW +: DW]), 4);
            chk("w00_e24", 64'(Window[24*DW +: DW]), 116);
        end
        if (idx == 1) chk("w01_e0", 64'(Window[0 +: DW]), 1);
        if (idx == NW - 1) begin
            chk("wlast_e0", 64'(Window[0 +: DW]), 667);
            chk("wlast_e24", 64'(Window[24*DW +: DW]), 783);
        end
    endtask

    task automatic walk(input bit rnd, input int stall_idx, input int restart_idx);
        int idx, cyc, stall, t_en, t_vld, rd0, dn0;
        bit stall_bad, restarted;
        logic [K*K*DW+9:0] snap;
        idx = 0; cyc = 0; stall = 0; t_en = -1; t_vld = -1;
        stall_bad = 0; restarted = 0; snap = '0;
        rd0 = rd_cnt; dn0 = done_cnt;
        Start = 1;
        @(negedge clk);
        Start = 0;
        while (idx < NW && cyc < 40000) begin
            if (Mem_Enable_Read && t_en < 0) t_en = cyc;
            if (Window_Valid && t_vld < 0) t_vld = cyc;
            Start = (idx == restart_idx) && !restarted;
            if (Start) restarted = 1;
            if (Window_Valid && idx == stall_idx && stall < 10) begin
                if (stall == 0) snap = {Window, Win_Row, Win_Col};
                else if ({Window, Win_Row, Win_Col} !== snap) stall_bad = 1;
                if (Mem_Enable_Read !== 1'b0) stall_bad = 1;
                stall++;
                Window_Ready = 0;
            end else begin
                Window_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (Window_Valid && Window_Ready) begin
                chk_win(idx);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        Start = 0;
        chk("handshakes", idx, NW);
        chk("first_latency", t_vld - t_en, K * K + 1);
        chk("done_pulse", {Done, Busy, Window_Valid}, 3'b100);
        @(negedge clk);
        chk("done_clear", {Done, Busy}, 0);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - dn0, 1);
        chk("read_count", rd_cnt - rd0, EXP_READS);
        if (stall_idx >= 0) begin
            chk("stall_stable", stall_bad, 0);
            chk("stall_len", stall, 10);
        end
    endtask

    initial begin
        int cyc, dn0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {Busy, Done, Mem_Enable_Read, Window_Valid, Mem_Address, Win_Row, Win_Col, |Window}, 0);
        rst = 0;
        @(negedge clk);
        // full walk with a 10-cycle stall at (2,3) and an ignored Start mid-walk
        walk(1'b0, 2 * NC + 3, 200);
        // reset while fetching window (5,7)
        Window_Ready = 1;
        Start = 1;
        @(negedge clk);
        Start = 0;
        cyc = 0;
        while (!(Mem_Enable_Read && Win_Row == 5 && Win_Col == 7) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_5_7", cyc < 8000, 1);
        repeat (3) @(negedge clk);
        chk("fetch_5_7", {Mem_Enable_Read, Busy, Window_Valid}, 3'b110);
        dn0 = done_cnt;
        rst = 1;
        @(negedge clk);
        chk("rst_mid_outputs", {Busy, Done, Mem_Enable_Read, Window_Valid, Mem_Address, Win_Row, Win_Col, |Window}, 0);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_cnt - dn0, 0);
        chk("rst_idle", {Busy, Mem_Enable_Read}, 0);
        // restart from (0,0) with random backpressure
        walk(1'b1, -1, -1);
        chk("max_addr", max_addr, IMG_W * IMG_H - 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
